zebra_stop_filter: RTL and testbench
====================================

ZEBRA_STOP_FILTER -- requirements
Module: zebra_stop_filter

Interface
REQ-001 Parameter ON_FRAMES, default 3: consecutive hit results needed to assert stop (legal range 1..15).
REQ-002 Parameter OFF_FRAMES, default 5: consecutive miss results needed to release stop (legal range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 25_000_000: clk cycles with no result before the filter is declared stale (about 1 s at the video clock).
REQ-004 clk  input  1  video clock; all logic is clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 detection_valid  input  1  level from the pattern-recognition stage; each rising edge marks one per-frame result.
REQ-007 crossing_detected  input  1  per-frame verdict, sampled only on a result strobe.
REQ-008 stop  output  1  filtered zebra-crossing stop request, registered.
REQ-009 stop_rise  output  1  one-cycle pulse when stop goes 0->1.
REQ-010 state  output  2  current FSM state encoding.
REQ-011 frame_count  output  16  saturating count of results since reset.
REQ-012 stale  output  1  high while the watchdog reports no recent results.

Function
REQ-013 Result strobe SHALL be detection_valid & ~dv_q, where dv_q is detection_valid registered once; hit = strobe & crossing_detected; miss = strobe & ~crossing_detected.
REQ-014 FSM states SHALL be IDLE=0, ARMING=1, STOP=2, RELEASE=3.
REQ-015 IDLE: on hit, go to ARMING with hit_cnt=1, or go directly to STOP if ON_FRAMES==1; on miss, stay in IDLE.
REQ-016 ARMING: on hit, hit_cnt++, and enter STOP when hit_cnt reaches ON_FRAMES; on miss, return to IDLE with hit_cnt=0.
REQ-017 STOP: on hit, stay; on miss, go to RELEASE with miss_cnt=1, or go directly to IDLE if OFF_FRAMES==1.
REQ-018 RELEASE: on miss, miss_cnt++, and enter IDLE when miss_cnt reaches OFF_FRAMES; on hit, return to STOP with miss_cnt=0.
REQ-019 stop SHALL be 1 exactly in STOP and RELEASE.
REQ-020 Latency: a strobe sampled in cycle N SHALL be reflected in state, stop and stop_rise from cycle N+1.
REQ-021 stop_rise SHALL be high for exactly one cycle on each IDLE/ARMING -> STOP transition, and never otherwise.
REQ-022 frame_count SHALL increment on every strobe and saturate at 16'hFFFF without wrapping.
REQ-023 Cycles with no strobe SHALL leave state, hit_cnt and miss_cnt unchanged.
REQ-024 A detection_valid level held high SHALL yield only one strobe.

Reset
REQ-025 While rst_n=0, asynchronously: state=IDLE, stop=0, stop_rise=0, frame_count=0, stale=0, hit_cnt=miss_cnt=0, dv_q=0, watchdog=0.
REQ-026 Reset asserted mid-STOP SHALL drop stop immediately, without waiting for a clock.
REQ-027 If detection_valid is high when rst_n releases, it SHALL produce no strobe until it goes low and then rises again.

Configuration
REQ-028 Macro ZEBRA_STOP_WATCHDOG_EN defined: a counter clears on every strobe and increments otherwise.
REQ-029 With the macro, when the counter reaches TIMEOUT_CYCLES-1: stale=1, state forced to IDLE, counters cleared, stop=0 on the next cycle; the counter holds there.
REQ-030 With the macro, the next strobe SHALL clear stale and be processed normally from IDLE; a strobe in the same cycle as the timeout takes priority.
REQ-031 Macro undefined: no watchdog logic, stale tied to 0, and stop may hold indefinitely.

Structure
REQ-032 Package zebra_pkg SHALL hold the state enum typedef (zebra_state_t), the default ON_FRAMES/OFF_FRAMES/TIMEOUT_CYCLES constants, and the counter widths.
REQ-033 One sub-module, sat_counter (parameterised width, clear/increment, saturating), SHALL be used for frame_count and the watchdog counter.

Verification
REQ-034 Three strobes with crossing_detected=1 -> state 0->1->1->2; stop=1 and stop_rise pulses once, one cycle after the third strobe.
REQ-035 Hit, hit, miss, hit, hit, hit -> stop stays 0 until after the sixth strobe; state returns to IDLE after the third strobe.
REQ-036 From STOP: four misses then one hit -> stop stays 1 and state returns to STOP; five consecutive misses -> stop=0, state=IDLE.
REQ-037 detection_valid held high 100 cycles with crossing_detected=1 -> frame_count=1, state=ARMING.
REQ-038 With ZEBRA_STOP_WATCHDOG_EN and TIMEOUT_CYCLES=50: enter STOP, then idle 50 cycles -> stale=1, stop=0; the next hit strobe -> stale=0, state=ARMING.
REQ-039 Assert rst_n=0 mid-RELEASE -> stop=0 within the same cycle; after release, a detection_valid already high gives no strobe.

Source files
------------

// File: rtl/zebra_stop_filter_pkg.sv
// Shared types and constants for the zebra-crossing stop filter.
package zebra_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_STOP    = 2'd2,
        ST_RELEASE = 2'd3
    } zebra_state_t;

    localparam int ON_FRAMES_DEF      = 3;
    localparam int OFF_FRAMES_DEF     = 5;
    localparam int TIMEOUT_CYCLES_DEF = 25_000_000;

    localparam int FRAME_CNT_W = 16;
    localparam int RUN_CNT_W   = 4;
    localparam int WDOG_W      = 25;

endpackage

// File: rtl/zebra_stop_filter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/zebra_stop_filter.sv
// Debounces per-frame zebra-crossing verdicts into a registered stop request.
// Optional stale-result watchdog enabled by ZEBRA_STOP_WATCHDOG_EN.
module zebra_stop_filter
    import zebra_pkg::*;
#(
    parameter int ON_FRAMES      = ON_FRAMES_DEF,
    parameter int OFF_FRAMES     = OFF_FRAMES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   detection_valid,
    input  logic                   crossing_detected,
    output logic                   stop,
    output logic                   stop_rise,
    output logic [1:0]             state,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   stale
);

    if (ON_FRAMES < 1 || ON_FRAMES > 15) begin : g_bad_on
        $error("ON_FRAMES must be 1..15");
    end
    if (OFF_FRAMES < 1 || OFF_FRAMES > 15) begin : g_bad_off
        $error("OFF_FRAMES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << WDOG_W)) begin : g_bad_to
        $error("TIMEOUT_CYCLES out of range");
    end

    zebra_state_t         st_q, st_d;
    logic [RUN_CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic                 dv_q, arm_q, stop_q, stop_d, rise_q, rise_d;
    logic                 strobe, hit, miss, timeout;

    // arm_q blocks a level that was already high when reset released
    assign strobe = detection_valid & ~dv_q & arm_q;
    assign hit    = strobe & crossing_detected;
    assign miss   = strobe & ~crossing_detected;

    sat_counter #(.W(FRAME_CNT_W)) u_frame_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (1'b0),
        .inc_i   (strobe),
        .count_o (frame_count)
    );

`ifdef ZEBRA_STOP_WATCHDOG_EN
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_at_limit, stale_q;

    assign wd_at_limit = (wd_cnt == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign timeout     = wd_at_limit & ~strobe;

    sat_counter #(.W(WDOG_W)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (strobe),
        .inc_i   (~wd_at_limit),
        .count_o (wd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       stale_q <= 1'b0;
        else if (strobe)  stale_q <= 1'b0;
        else if (timeout) stale_q <= 1'b1;
    end

    assign stale = stale_q;
`else
    assign timeout = 1'b0;
    assign stale   = 1'b0;
`endif

    always_comb begin
        st_d   = st_q;
        hit_d  = hit_q;
        miss_d = miss_q;
        unique case (st_q)
            ST_IDLE: if (hit) begin
                if (ON_FRAMES == 1) st_d = ST_STOP;
                else begin
                    st_d  = ST_ARMING;
                    hit_d = RUN_CNT_W'(1);
                end
            end
            ST_ARMING: if (hit) begin
                if (hit_q + RUN_CNT_W'(1) == RUN_CNT_W'(ON_FRAMES)) begin
                    st_d  = ST_STOP;
                    hit_d = '0;
                end else begin
                    hit_d = hit_q + RUN_CNT_W'(1);
                end
            end else if (miss) begin
                st_d  = ST_IDLE;
                hit_d = '0;
            end
            ST_STOP: if (miss) begin
                if (OFF_FRAMES == 1) st_d = ST_IDLE;
                else begin
                    st_d   = ST_RELEASE;
                    miss_d = RUN_CNT_W'(1);
                end
            end
            ST_RELEASE: if (miss) begin
                if (miss_q + RUN_CNT_W'(1) == RUN_CNT_W'(OFF_FRAMES)) begin
                    st_d   = ST_IDLE;
                    miss_d = '0;
                end else begin
                    miss_d = miss_q + RUN_CNT_W'(1);
                end
            end else if (hit) begin
                st_d   = ST_STOP;
                miss_d = '0;
            end
            default: st_d = ST_IDLE;
        endcase
        if (timeout) begin
            st_d   = ST_IDLE;
            hit_d  = '0;
            miss_d = '0;
        end
        stop_d = (st_d == ST_STOP) || (st_d == ST_RELEASE);
        rise_d = (st_d == ST_STOP) && ((st_q == ST_IDLE) || (st_q == ST_ARMING));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            hit_q  <= '0;
            miss_q <= '0;
            dv_q   <= 1'b0;
            arm_q  <= 1'b0;
            stop_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            dv_q   <= detection_valid;
            arm_q  <= arm_q | ~detection_valid;
            stop_q <= stop_d;
            rise_q <= rise_d;
        end
    end

    assign stop      = stop_q;
    assign stop_rise = rise_q;
    assign state     = st_q;

endmodule

// File: tb/tb_zebra_stop_filter.sv
// Directed-vector bench for zebra_stop_filter (ON=3, OFF=5, TIMEOUT=50).
module tb_zebra_stop_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        detection_valid = 1'b0;
    logic        crossing_detected = 1'b0;
    logic        stop, stop_rise, stale;
    logic [1:0]  state;
    logic [15:0] frame_count;

    int n_vec = 0;
    int n_err = 0;

    zebra_stop_filter #(
        .ON_FRAMES      (3),
        .OFF_FRAMES     (5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .detection_valid   (detection_valid),
        .crossing_detected (crossing_detected),
        .stop              (stop),
        .stop_rise         (stop_rise),
        .state             (state),
        .frame_count       (frame_count),
        .stale             (stale)
    );

    always #5 clk = ~clk;

    // Raise detection_valid for one cycle; returns at the negedge of the cycle
    // after the strobe, where the result must already be visible.
    task automatic pulse(input logic c);
        @(negedge clk);
        detection_valid   = 1'b1;
        crossing_detected = c;
        @(negedge clk);
        detection_valid   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        detection_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (state !== 2'd0) begin $display("FAIL rst_state got %0d want 0", state); n_err++; end
        n_vec++; if (stop !== 1'b0) begin $display("FAIL rst_stop got %0b want 0", stop); n_err++; end
        n_vec++; if (stop_rise !== 1'b0) begin $display("FAIL rst_rise got %0b want 0", stop_rise); n_err++; end
        n_vec++; if (frame_count !== 16'd0) begin $display("FAIL rst_fc got %0d want 0", frame_count); n_err++; end
        n_vec++; if (stale !== 1'b0) begin $display("FAIL rst_stale got %0b want 0", stale); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_on_sequence();
        pulse(1'b1);
        n_vec++; if (state !== 2'd1) begin $display("FAIL on1_state got %0d want 1", state); n_err++; end
        pulse(1'b1);
        n_vec++; if (state !== 2'd1) begin $display("FAIL on2_state got %0d want 1", state); n_err++; end
        n_vec++; if (stop !== 1'b0) begin $display("FAIL on2_stop got %0b want 0", stop); n_err++; end
        pulse(1'b1);
        n_vec++; if (state !== 2'd2) begin $display("FAIL on3_state got %0d want 2", state); n_err++; end
        n_vec++; if (stop !== 1'b1) begin $display("FAIL on3_stop got %0b want 1", stop); n_err++; end
        n_vec++; if (stop_rise !== 1'b1) begin $display("FAIL on3_rise got %0b want 1", stop_rise); n_err++; end
        @(negedge clk);
        n_vec++; if (stop_rise !== 1'b0) begin $display("FAIL on3_rise_end got %0b want 0", stop_rise); n_err++; end
        n_vec++; if (frame_count !== 16'd3) begin $display("FAIL on_fc got %0d want 3", frame_count); n_err++; end
    endtask

    task automatic test_release();
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0);
            n_vec++; if (state !== 2'd3 || stop !== 1'b1) begin
                $display("FAIL rel_miss%0d got state %0d stop %0b want 3/1", i + 1, state, stop); n_err++;
            end
        end
        pulse(1'b1);
        n_vec++; if (state !== 2'd2) begin $display("FAIL rel_back_state got %0d want 2", state); n_err++; end
        n_vec++; if (stop_rise !== 1'b0) begin $display("FAIL rel_back_rise got %0b want 0", stop_rise); n_err++; end
        for (int i = 0; i < 4; i++) pulse(1'b0);
        n_vec++; if (state !== 2'd3 || stop !== 1'b1) begin
            $display("FAIL rel_4miss got state %0d stop %0b want 3/1", state, stop); n_err++;
        end
        pulse(1'b0);
        n_vec++; if (state !== 2'd0) begin $display("FAIL rel_5miss_state got %0d want 0", state); n_err++; end
        n_vec++; if (stop !== 1'b0) begin $display("FAIL rel_5miss_stop got %0b want 0", stop); n_err++; end
        n_vec++; if (frame_count !== 16'd13) begin $display("FAIL rel_fc got %0d want 13", frame_count); n_err++; end
    endtask

    task automatic test_broken_run();
        pulse(1'b1);
        pulse(1'b1);
        pulse(1'b0);
        n_vec++; if (state !== 2'd0) begin $display("FAIL brk_miss_state got %0d want 0", state); n_err++; end
        pulse(1'b1);
        pulse(1'b1);
        n_vec++; if (state !== 2'd1 || stop !== 1'b0) begin
            $display("FAIL brk_5th got state %0d stop %0b want 1/0", state, stop); n_err++;
        end
        pulse(1'b1);
        n_vec++; if (state !== 2'd2 || stop !== 1'b1 || stop_rise !== 1'b1) begin
            $display("FAIL brk_6th got state %0d stop %0b rise %0b want 2/1/1", state, stop, stop_rise); n_err++;
        end
        n_vec++; if (frame_count !== 16'd19) begin $display("FAIL brk_fc got %0d want 19", frame_count); n_err++; end
    endtask

    task automatic test_held_high();
        do_reset();
        @(negedge clk);
        detection_valid   = 1'b1;
        crossing_detected = 1'b1;
        repeat (100) @(negedge clk);
        n_vec++; if (frame_count !== 16'd1) begin $display("FAIL held_fc got %0d want 1", frame_count); n_err++; end
        n_vec++; if (state !== 2'd1) begin $display("FAIL held_state got %0d want 1", state); n_err++; end
        detection_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_release();
        pulse(1'b1);
        pulse(1'b1);
        n_vec++; if (state !== 2'd2) begin $display("FAIL rmr_stop_state got %0d want 2", state); n_err++; end
        pulse(1'b0);
        n_vec++; if (state !== 2'd3) begin $display("FAIL rmr_rel_state got %0d want 3", state); n_err++; end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        detection_valid   = 1'b1;
        crossing_detected = 1'b1;
        #1;
        n_vec++; if (stop !== 1'b0) begin $display("FAIL rmr_async_stop got %0b want 0", stop); n_err++; end
        n_vec++; if (state !== 2'd0) begin $display("FAIL rmr_async_state got %0d want 0", state); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++; if (frame_count !== 16'd0 || state !== 2'd0) begin
            $display("FAIL rmr_held_nostrobe got fc %0d state %0d want 0/0", frame_count, state); n_err++;
        end
        detection_valid = 1'b0;
        pulse(1'b1);
        n_vec++; if (frame_count !== 16'd1 || state !== 2'd1) begin
            $display("FAIL rmr_new_strobe got fc %0d state %0d want 1/1", frame_count, state); n_err++;
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        pulse(1'b1);
        pulse(1'b1);
        pulse(1'b1);
        n_vec++; if (state !== 2'd2) begin $display("FAIL wd_enter_state got %0d want 2", state); n_err++; end
        repeat (40) @(negedge clk);
        n_vec++; if (stale !== 1'b0 || stop !== 1'b1) begin
            $display("FAIL wd_early got stale %0b stop %0b want 0/1", stale, stop); n_err++;
        end
        repeat (20) @(negedge clk);
`ifdef ZEBRA_STOP_WATCHDOG_EN
        n_vec++; if (stale !== 1'b1 || stop !== 1'b0 || state !== 2'd0) begin
            $display("FAIL wd_timeout got stale %0b stop %0b state %0d want 1/0/0", stale, stop, state); n_err++;
        end
        pulse(1'b1);
        n_vec++; if (stale !== 1'b0 || state !== 2'd1) begin
            $display("FAIL wd_recover got stale %0b state %0d want 0/1", stale, state); n_err++;
        end
`else
        n_vec++; if (stale !== 1'b0 || stop !== 1'b1 || state !== 2'd2) begin
            $display("FAIL wd_off_hold got stale %0b stop %0b state %0d want 0/1/2", stale, stop, state); n_err++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_on_sequence();
        test_release();
        test_broken_run();
        test_held_high();
        test_reset_mid_release();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
